// File: rtl/cpu_pkg.sv
// Shared CPU datapath types: default register-file geometry, address and word types.
package cpu_pkg;

  localparam int unsigned WORD_W = 16;
  localparam int unsigned NREGS  = 16;

  typedef logic [$clog2(NREGS)-1:0] reg_addr_t;
  typedef logic [WORD_W-1:0]        word_t;

endpackage

// File: rtl/reg_file_if.sv
// Register-file bus: writeback write port, decode mark port and two operand read ports.
//   master: writeback/decode/operand-fetch side (drives requests, receives read data)
//   slave : reg_file
interface reg_file_if
  import cpu_pkg::*;
#(
  parameter int unsigned WIDTH = WORD_W,
  parameter int unsigned DEPTH = NREGS
);
  localparam int unsigned AW = $clog2(DEPTH);

  logic             we;
  logic [AW-1:0]    waddr;
  logic [WIDTH-1:0] wdata;
  logic             mark;
  logic [AW-1:0]    mark_addr;
  logic             re_a;
  logic [AW-1:0]    raddr_a;
  logic             re_b;
  logic [AW-1:0]    raddr_b;
  logic [WIDTH-1:0] rdata_a;
  logic             rvalid_a;
  logic             rbusy_a;
  logic [WIDTH-1:0] rdata_b;
  logic             rvalid_b;
  logic             rbusy_b;

  modport master (
    output we, waddr, wdata, mark, mark_addr,
    output re_a, raddr_a, re_b, raddr_b,
    input  rdata_a, rvalid_a, rbusy_a,
    input  rdata_b, rvalid_b, rbusy_b
  );

  modport slave (
    input  we, waddr, wdata, mark, mark_addr,
    input  re_a, raddr_a, re_b, raddr_b,
    output rdata_a, rvalid_a, rbusy_a,
    output rdata_b, rvalid_b, rbusy_b
  );

endinterface

// File: rtl/reg_read_port.sv
// One registered operand read port of the register file.
//   clk, rst_n          : clock, synchronous active-low reset
//   mem, pend           : current storage array and pending vector
//   we/waddr/wdata      : same-cycle write, bypassed into the read
//   mark/mark_addr      : same-cycle mark, bypassed into the busy bit
//   re/raddr            : read request
//   rdata/rvalid/rbusy  : registered read response (one cycle latency)
module reg_read_port
  import cpu_pkg::*;
#(
  parameter int unsigned WIDTH    = WORD_W,
  parameter int unsigned DEPTH    = NREGS,
  parameter bit          ZERO_REG = 1'b0,
  parameter int unsigned AW       = $clog2(DEPTH)
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [DEPTH-1:0][WIDTH-1:0] mem,
  input  logic [DEPTH-1:0]            pend,
  input  logic                        we,
  input  logic [AW-1:0]               waddr,
  input  logic [WIDTH-1:0]            wdata,
  input  logic                        mark,
  input  logic [AW-1:0]               mark_addr,
  input  logic                        re,
  input  logic [AW-1:0]               raddr,
  output logic [WIDTH-1:0]            rdata,
  output logic                        rvalid,
  output logic                        rbusy
);

  localparam logic [AW:0] DEPTH_L = (AW+1)'(DEPTH);

  logic             in_range;
  logic             hidden;
  logic             wr_hit;
  logic             mk_hit;
  logic [WIDTH-1:0] arr_data;
  logic             arr_busy;
  logic [WIDTH-1:0] data_c;
  logic             busy_c;

  // Select, bypass and mask; out-of-range and hard-zero addresses read as 0/not busy.
  always_comb begin
    in_range = ({1'b0, raddr} < DEPTH_L);
    hidden   = !in_range || (ZERO_REG && (raddr == '0));
    wr_hit   = we && (waddr == raddr);
    mk_hit   = mark && (mark_addr == raddr);
    arr_data = '0;
    arr_busy = 1'b0;
    if (in_range) begin
      arr_data = mem[raddr];
      arr_busy = pend[raddr];
    end
    data_c = wr_hit ? wdata : arr_data;
    // A same-cycle mark beats a same-cycle write clear.
    busy_c = mk_hit | (arr_busy & ~wr_hit);
    if (hidden) begin
      data_c = '0;
      busy_c = 1'b0;
    end
  end

  // Output registers; data and busy hold when no read is issued.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rdata  <= '0;
      rbusy  <= 1'b0;
      rvalid <= 1'b0;
    end else begin
      rvalid <= re;
      if (re) begin
        rdata <= data_c;
        rbusy <= busy_c;
      end
    end
  end

endmodule

// File: rtl/reg_file.sv
// Multi-port CPU register file: storage array, per-register pending bits and
// two independent registered read ports with write/mark bypass.
//   clk   : clock, rising edge
//   rst_n : synchronous active-low reset
//   rf    : register-file bus (slave side)
module reg_file
  import cpu_pkg::*;
#(
  parameter int unsigned WIDTH    = WORD_W,
  parameter int unsigned DEPTH    = NREGS,
  parameter bit          ZERO_REG = 1'b0
) (
  input  logic       clk,
  input  logic       rst_n,
  reg_file_if.slave  rf
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [DEPTH-1:0][WIDTH-1:0] mem_q;
  logic [DEPTH-1:0]            pend_q;
  logic [DEPTH-1:0]            pend_d;
  logic [DEPTH-1:0]            wr_hit;
  logic [DEPTH-1:0]            mk_hit;

  // Per-register write/mark decode; addresses beyond DEPTH match nothing and are dropped.
  always_comb begin
    wr_hit = '0;
    mk_hit = '0;
    pend_d = pend_q;
    for (int i = 0; i < int'(DEPTH); i++) begin
      if (!(ZERO_REG && (i == 0))) begin
        wr_hit[i] = rf.we   && (rf.waddr     == AW'(i));
        mk_hit[i] = rf.mark && (rf.mark_addr == AW'(i));
      end
      pend_d[i] = mk_hit[i] | (pend_q[i] & ~wr_hit[i]);
    end
  end

  // Storage array and pending vector.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mem_q  <= '0;
      pend_q <= '0;
    end else begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        if (wr_hit[i]) mem_q[i] <= rf.wdata;
      end
      pend_q <= pend_d;
    end
  end

  reg_read_port #(
    .WIDTH    (WIDTH),
    .DEPTH    (DEPTH),
    .ZERO_REG (ZERO_REG),
    .AW       (AW)
  ) u_port_a (
    .clk       (clk),
    .rst_n     (rst_n),
    .mem       (mem_q),
    .pend      (pend_q),
    .we        (rf.we),
    .waddr     (rf.waddr),
    .wdata     (rf.wdata),
    .mark      (rf.mark),
    .mark_addr (rf.mark_addr),
    .re        (rf.re_a),
    .raddr     (rf.raddr_a),
    .rdata     (rf.rdata_a),
    .rvalid    (rf.rvalid_a),
    .rbusy     (rf.rbusy_a)
  );

  reg_read_port #(
    .WIDTH    (WIDTH),
    .DEPTH    (DEPTH),
    .ZERO_REG (ZERO_REG),
    .AW       (AW)
  ) u_port_b (
    .clk       (clk),
    .rst_n     (rst_n),
    .mem       (mem_q),
    .pend      (pend_q),
    .we        (rf.we),
    .waddr     (rf.waddr),
    .wdata     (rf.wdata),
    .mark      (rf.mark),
    .mark_addr (rf.mark_addr),
    .re        (rf.re_b),
    .raddr     (rf.raddr_b),
    .rdata     (rf.rdata_b),
    .rvalid    (rf.rvalid_b),
    .rbusy     (rf.rbusy_b)
  );

endmodule

// File: doc/reg_file.md
# reg_file

Parametrised multi-port CPU register file with registered read ports, write-to-read bypass and a per-register pending (scoreboard) bit. It supersedes the flat 16:1 register-select mux. The storage array, both operand read ports and hazard tracking now live in one clocked block between the decode stage and the ALU. The write port is driven by writeback.

## Interface
- WIDTH, 16, data width of each register
- DEPTH, 16, number of registers (2..256; need not be a power of two)
- AW, $clog2(DEPTH), address width (derived; never overridden)
- ZERO_REG, 0, when 1, register 0 reads as zero and ignores writes and marks
- clk  in  1  single clock, rising edge
- rst_n  in  1  synchronous, active-low reset
- we  in  1  write enable (writeback)
- waddr  in  AW  write address
- wdata  in  WIDTH  write data
- mark  in  1  set the pending bit of mark_addr (decode issued a producer)
- mark_addr  in  AW  register to mark pending
- re_a / re_b  in  1  read enable, port A / B
- raddr_a / raddr_b  in  AW  read address, port A / B
- rdata_a / rdata_b  out  WIDTH  registered read data
- rvalid_a / rvalid_b  out  1  rdata updated by a read issued in the previous cycle
- rbusy_a / rbusy_b  out  1  pending bit of the read register, sampled with rdata

## Operation
- Reset (rst_n low at a rising edge):
  - all registers := 0; all pending bits := 0.
  - rdata_* := 0; rvalid_* := 0; rbusy_* := 0.
  - Reset overrides we, mark and re_* in that cycle.
- Write: when we=1, reg[waddr] := wdata and pending[waddr] := 0 at the edge.
- Mark: when mark=1, pending[mark_addr] := 1.
  - If mark and a write hit the same address in the same cycle, mark wins: the data is written and the bit stays 1.
- Read port X, when re_X=1:
  - rdata_X := bypassed value of raddr_X; rbusy_X := bypassed pending bit; rvalid_X := 1.
  - Bypass, data: if we=1 and waddr==raddr_X, the value is wdata; otherwise it is reg[raddr_X].
  - Bypass, pending: the write clears the bit and a mark sets it, with mark taking priority.
- When re_X=0: rdata_X and rbusy_X hold their previous values; rvalid_X := 0.
- Both ports are fully independent. Same address on A and B returns identical data.
- ZERO_REG=1:
  - address 0 always reads 0 with rbusy 0.
  - writes and marks to address 0 are dropped.
- Address >= DEPTH (non-power-of-two DEPTH):
  - read returns 0 with rbusy 0, and rvalid still asserts.
  - writes and marks to such an address are dropped.

## Timing
- Read latency is 1 cycle: the address sampled at edge N appears on rdata at edge N (valid during cycle N+1).
- Write-to-read latency is 0 through the bypass. A write and a read of the same address in the same cycle return the new data.
- The write becomes visible in the array at the edge.
- The pending bit is visible to a read one cycle after a mark, or in the same cycle through the bypass.
- There is no stall or backpressure. Every request is accepted in its cycle.
- Deasserting rst_n mid-operation discards any in-flight read. rvalid is 0 in the cycle after reset.

## Structure
- Shared package cpu_pkg:
  - WORD_W (16) and NREGS (16) defaults.
  - typedef reg_addr_t (logic [$clog2(NREGS)-1:0]).
  - typedef word_t.
- Storage array and pending vector live in reg_file.
- Sub-module reg_read_port contains the array select mux, bypass compare, zero/out-of-range masking and output registers. It is instantiated twice (A, B).

## Test plan
- Reset: load reg5=16'hBEEF, assert rst_n=0 for 1 cycle, then read 5 on A -> rdata_a=0, rbusy_a=0; rvalid_a=0 in the first cycle after reset.
- Basic write/read: write reg3=16'h1234, next cycle re_a with raddr_a=3 -> rdata_a=16'h1234 and rvalid_a=1 one cycle later; rdata_a holds when re_a=0.
- Bypass: in the same cycle drive we, waddr=7, wdata=16'hA5A5 and re_b, raddr_b=7 -> rdata_b=16'hA5A5 next cycle.
- Scoreboard:
  - mark reg9, then read reg9 -> rbusy=1.
  - write reg9=16'h0042 -> a read in the same cycle returns 16'h0042 with rbusy=0.
  - mark and write reg9 together -> rbusy=1.
- ZERO_REG=1 / DEPTH=12: write reg0=16'hFFFF -> reads 0; read address 13 -> rdata=0, rvalid=1; write to 13 leaves all registers unchanged.
- Dual port: A and B read the same address and different addresses back-to-back for 100 random cycles against a reference model, with zero mismatches.
